// File: rtl/expmul_array.sv
// N-channel base-2 exponent rescale: out = 2^-(b - a[c]) * v[c][e], joined valid/ready pipeline.
// Optional underflow counter port enabled by defining EXPMUL_UNDERFLOW_CNT_EN.
module expmul_array #(
    parameter int NUM_CH  = 2,
    parameter int VEC_LEN = 16,
    parameter int ELEM_W  = 16,
    parameter int DIFF_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int STAGES  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               vld_in,
    output logic                               rdy_out,
    output logic                               vld_out,
    input  logic                               rdy_in,
    input  logic [DIFF_W-1:0]                  b_in,
    input  logic [NUM_CH*DIFF_W-1:0]           a_in,
    input  logic [NUM_CH*VEC_LEN*ELEM_W-1:0]   v_in,
    output logic [NUM_CH*VEC_LEN*ELEM_W-1:0]   v_out
`ifdef EXPMUL_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                        uflow_cnt
`endif
);
    localparam int KW = DIFF_W + 1 - FRAC_W;
    localparam int NE = NUM_CH * VEC_LEN;
    localparam int NW = NE * ELEM_W;
    localparam int PW = ELEM_W + FRAC_W + 1;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_up;
    logic [STAGES-1:0] w_load;
    logic              w_rr;
    logic [DIFF_W:0]   w_d;
    logic [NUM_CH*KW-1:0]     w_k_in;
    logic [NUM_CH*FRAC_W-1:0] w_f_in;
    logic [NW-1:0]            r_out;

    // t = v - ((v * f) >>> (FRAC_W+1)), i.e. v * (1 - f/2)
    function automatic logic [NW-1:0] f_tvec(input logic [NW-1:0] v, input logic [NUM_CH*FRAC_W-1:0] f);
        logic signed [ELEM_W-1:0] e;
        logic signed [PW-1:0]     ev;
        logic signed [PW-1:0]     fv;
        logic signed [PW-1:0]     prod;
        logic signed [PW-1:0]     sh;
        logic signed [ELEM_W-1:0] p;
        f_tvec = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned i = 0; i < VEC_LEN; i++) begin
                e    = v[(c*VEC_LEN+i)*ELEM_W +: ELEM_W];
                ev   = {{(FRAC_W+1){e[ELEM_W-1]}}, e};
                fv   = {{ELEM_W{1'b0}}, 1'b0, f[c*FRAC_W +: FRAC_W]};
                prod = ev * fv;
                sh   = prod >>> (FRAC_W + 1);
                p    = sh[ELEM_W-1:0];
                f_tvec[(c*VEC_LEN+i)*ELEM_W +: ELEM_W] = e - p;
            end
        end
    endfunction

    function automatic logic [NW-1:0] f_svec(input logic [NW-1:0] t, input logic [NUM_CH*KW-1:0] k);
        logic signed [ELEM_W-1:0] te;
        logic [KW-1:0]            kk;
        f_svec = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            kk = k[c*KW +: KW];
            for (int unsigned i = 0; i < VEC_LEN; i++) begin
                te = t[(c*VEC_LEN+i)*ELEM_W +: ELEM_W];
                if (int'(kk) >= ELEM_W)
                    f_svec[(c*VEC_LEN+i)*ELEM_W +: ELEM_W] = '0;
                else
                    f_svec[(c*VEC_LEN+i)*ELEM_W +: ELEM_W] = te >>> kk;
            end
        end
    endfunction

`ifdef EXPMUL_UNDERFLOW_CNT_EN
    logic [NE-1:0] r_uf;
    logic [15:0]   r_ucnt;
    logic [16:0]   w_sum;

    function automatic logic [NE-1:0] f_nz(input logic [NW-1:0] v);
        for (int unsigned i = 0; i < NE; i++)
            f_nz[i] = (v[i*ELEM_W +: ELEM_W] != '0);
    endfunction

    function automatic logic [NE-1:0] f_uf(input logic [NE-1:0] nz, input logic [NUM_CH*KW-1:0] k,
                                           input logic [NW-1:0] o);
        for (int unsigned c = 0; c < NUM_CH; c++)
            for (int unsigned i = 0; i < VEC_LEN; i++)
                f_uf[c*VEC_LEN+i] = (int'(k[c*KW +: KW]) >= ELEM_W) ||
                                    (nz[c*VEC_LEN+i] && (o[(c*VEC_LEN+i)*ELEM_W +: ELEM_W] == '0));
    endfunction
`endif

    // Ready ripples from the output back; a temp keeps the chain free of self-reads.
    always_comb begin
        w_rdy = '0;
        w_up  = '0;
        w_rr  = rdy_in;
        for (int unsigned j = 0; j < STAGES; j++) begin
            w_rr = !r_vld[STAGES-1-j] || w_rr;
            w_rdy[STAGES-1-j] = w_rr;
        end
        w_up[0] = vld_in;
        for (int unsigned j = 1; j < STAGES; j++)
            w_up[j] = r_vld[j-1];
        w_load = w_rdy & w_up;
    end

    assign rdy_out = w_rdy[0];
    assign vld_out = r_vld[STAGES-1];
    assign v_out   = r_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_vld <= '0;
        else     r_vld <= (w_rdy & w_up) | (~w_rdy & r_vld);
    end

    always_comb begin
        w_d    = '0;
        w_k_in = '0;
        w_f_in = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_d = {b_in[DIFF_W-1], b_in} - {a_in[c*DIFF_W+DIFF_W-1], a_in[c*DIFF_W +: DIFF_W]};
            if (w_d[DIFF_W]) w_d = '0;
            w_k_in[c*KW +: KW]         = w_d[DIFF_W:FRAC_W];
            w_f_in[c*FRAC_W +: FRAC_W] = w_d[FRAC_W-1:0];
        end
    end

    generate
        if (STAGES == 1) begin : g_s1
            logic [NW-1:0] w_res;
            assign w_res = f_svec(f_tvec(v_in, w_f_in), w_k_in);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= '0;
`ifdef EXPMUL_UNDERFLOW_CNT_EN
                    r_uf  <= '0;
`endif
                end else if (w_load[0]) begin
                    r_out <= w_res;
`ifdef EXPMUL_UNDERFLOW_CNT_EN
                    r_uf  <= f_uf(f_nz(v_in), w_k_in, w_res);
`endif
                end
            end
        end else begin : g_sn
            logic [NUM_CH*KW-1:0]     r_k1;
            logic [NUM_CH*FRAC_W-1:0] r_f1;
            logic [NW-1:0]            r_v1;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_k1 <= '0;
                    r_f1 <= '0;
                    r_v1 <= '0;
                end else if (w_load[0]) begin
                    r_k1 <= w_k_in;
                    r_f1 <= w_f_in;
                    r_v1 <= v_in;
                end
            end
            if (STAGES == 2) begin : g_s2
                logic [NW-1:0] w_res;
                assign w_res = f_svec(f_tvec(r_v1, r_f1), r_k1);
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_out <= '0;
`ifdef EXPMUL_UNDERFLOW_CNT_EN
                        r_uf  <= '0;
`endif
                    end else if (w_load[1]) begin
                        r_out <= w_res;
`ifdef EXPMUL_UNDERFLOW_CNT_EN
                        r_uf  <= f_uf(f_nz(r_v1), r_k1, w_res);
`endif
                    end
                end
            end else begin : g_s3
                logic [NUM_CH*KW-1:0] r_k2;
                logic [NW-1:0]        r_t2;
                logic [NW-1:0]        w_res;
`ifdef EXPMUL_UNDERFLOW_CNT_EN
                logic [NE-1:0]        r_nz2;
`endif
                assign w_res = f_svec(r_t2, r_k2);
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_k2  <= '0;
                        r_t2  <= '0;
`ifdef EXPMUL_UNDERFLOW_CNT_EN
                        r_nz2 <= '0;
`endif
                    end else if (w_load[1]) begin
                        r_k2  <= r_k1;
                        r_t2  <= f_tvec(r_v1, r_f1);
`ifdef EXPMUL_UNDERFLOW_CNT_EN
                        r_nz2 <= f_nz(r_v1);
`endif
                    end
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_out <= '0;
`ifdef EXPMUL_UNDERFLOW_CNT_EN
                        r_uf  <= '0;
`endif
                    end else if (w_load[2]) begin
                        r_out <= w_res;
`ifdef EXPMUL_UNDERFLOW_CNT_EN
                        r_uf  <= f_uf(r_nz2, r_k2, w_res);
`endif
                    end
                end
            end
        end
    endgenerate

`ifdef EXPMUL_UNDERFLOW_CNT_EN
    always_comb w_sum = {1'b0, r_ucnt} + 17'($countones(r_uf));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_ucnt <= '0;
        else if (vld_out && rdy_in) r_ucnt <= w_sum[16] ? '1 : w_sum[15:0];
    end

    assign uflow_cnt = r_ucnt;
`endif
endmodule

// File: tb/tb_expmul_array.sv
// Directed self-checking bench for expmul_array (STAGES=2 and STAGES=3 instances).
// Underflow counter checks are included when EXPMUL_UNDERFLOW_CNT_EN is defined.
module tb_expmul_array;
    localparam int NC = 2;
    localparam int VL = 16;
    localparam int EW = 16;
    localparam int DW = 16;
    localparam int NW = NC * VL * EW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vld2 = 1'b0, rdy2 = 1'b1, rdy_out2, vld_out2;
    logic          vld3 = 1'b0, rdy3 = 1'b1, rdy_out3, vld_out3;
    logic [DW-1:0]    b = '0;
    logic [NC*DW-1:0] a = '0;
    logic [NW-1:0]    v = '0;
    logic [NW-1:0]    v_out2, v_out3;
`ifdef EXPMUL_UNDERFLOW_CNT_EN
    logic [15:0]      ucnt2, ucnt3;
`endif
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    expmul_array #(.NUM_CH(NC), .VEC_LEN(VL), .ELEM_W(EW), .DIFF_W(DW), .FRAC_W(8), .STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .vld_in(vld2), .rdy_out(rdy_out2), .vld_out(vld_out2), .rdy_in(rdy2),
        .b_in(b), .a_in(a), .v_in(v), .v_out(v_out2)
`ifdef EXPMUL_UNDERFLOW_CNT_EN
        , .uflow_cnt(ucnt2)
`endif
    );

    expmul_array #(.NUM_CH(NC), .VEC_LEN(VL), .ELEM_W(EW), .DIFF_W(DW), .FRAC_W(8), .STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .vld_in(vld3), .rdy_out(rdy_out3), .vld_out(vld_out3), .rdy_in(rdy3),
        .b_in(b), .a_in(a), .v_in(v), .v_out(v_out3)
`ifdef EXPMUL_UNDERFLOW_CNT_EN
        , .uflow_cnt(ucnt3)
`endif
    );

    task automatic check(input string tag, input longint act, input longint expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, expv);
        end
    endtask

    function automatic logic [NW-1:0] fill(input logic [15:0] x0, input logic [15:0] x1);
        logic [NW-1:0] w;
        w = '0;
        for (int e = 0; e < VL; e++) begin
            w[e*EW +: EW]      = x0;
            w[(VL+e)*EW +: EW] = x1;
        end
        return w;
    endfunction

    function automatic logic signed [15:0] el(input logic [NW-1:0] w, input int c, input int e);
        return w[(c*VL+e)*EW +: EW];
    endfunction

    task automatic beat2(input string tag, input logic [15:0] bb, input logic [15:0] aa0, input logic [15:0] aa1,
                         input logic [15:0] x0, input logic [15:0] x1,
                         input logic signed [15:0] e0, input logic signed [15:0] e1);
        @(negedge clk);
        b = bb; a = {aa1, aa0}; v = fill(x0, x1); vld2 = 1'b1;
        check({tag, "_rdy"}, rdy_out2, 1);
        @(negedge clk);
        vld2 = 1'b0;
        check({tag, "_lat1"}, vld_out2, 0);
        @(negedge clk);
        check({tag, "_vld"},   vld_out2, 1);
        check({tag, "_c0e0"},  el(v_out2, 0, 0),  e0);
        check({tag, "_c0e15"}, el(v_out2, 0, 15), e0);
        check({tag, "_c1e0"},  el(v_out2, 1, 0),  e1);
        check({tag, "_c1e15"}, el(v_out2, 1, 15), e1);
    endtask

`ifdef EXPMUL_UNDERFLOW_CNT_EN
    task automatic stream2(input int n);
        @(negedge clk);
        vld2 = 1'b1;
        repeat (n) @(negedge clk);
        vld2 = 1'b0;
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] got[8];
        int ng;
        int stale;

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_vld_out", vld_out2, 0);
        check("rst_v_out",   el(v_out2, 0, 0), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy_out", rdy_out2, 1);

        // Exponent and sign cases on the 2-stage instance
        beat2("eq_d100",   16'h0300, 16'h0300, 16'h0200, 16'd1024, 16'd1024, 16'sd1024, 16'sd512);
        beat2("f80_neg",   16'h0080, 16'h0000, 16'h0180, 16'd1024, 16'd1024, 16'sd768,  16'sd1024);
        beat2("k16_neg",   16'h1000, 16'h0000, 16'h0F00, 16'd1024, 16'hFC00, 16'sd0,    -16'sd512);
        beat2("floor",     16'h0100, 16'h0000, 16'h0100, 16'hFFFD, 16'hFFFD, -16'sd2,   -16'sd3);
        beat2("k16n_k15",  16'h1000, 16'h0000, 16'h0100, 16'hFFFB, 16'hFC00, 16'sd0,    -16'sd1);
        beat2("fFF",       16'h00FF, 16'h0000, 16'h0000, 16'd1024, 16'hFFFF, 16'sd514,  16'sd0);
        beat2("extreme",   16'h7FFF, 16'h8000, 16'h7FFF, 16'd1000, 16'h8000, 16'sd0,    -16'sd32768);

        // Backpressure on the 3-stage instance
        @(negedge clk);
        b = '0; a = '0; rdy3 = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            if (n > 1) @(negedge clk);
            v = fill(16'(n * 100), 16'(n * 100 + 1)); vld3 = 1'b1;
            check("bp_rdy", rdy_out3, 1);
        end
        @(negedge clk);
        v = fill(16'd400, 16'd401);
        check("bp_full", rdy_out3, 0);
        check("bp_vo",   vld_out3, 1);
        @(negedge clk);
        check("bp_hold_rdy", rdy_out3, 0);
        check("bp_hold_dat", el(v_out3, 0, 0), 100);
        rdy3 = 1'b1;
        #1;
        check("bp_comb_rdy", rdy_out3, 1);
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) vld3 = 1'b0;
            if (vld_out3) begin
                if (ng < 8) got[ng] = el(v_out3, 1, 3);
                ng++;
            end
        end
        check("bp_count", ng, 4);
        for (int i = 0; i < 4; i++)
            check("bp_order", got[i], (i + 1) * 100 + 1);
        check("bp_drained", vld_out3, 0);

        // Reset with two beats in flight
        @(negedge clk);
        v = fill(16'd11, 16'd12); vld2 = 1'b1;
        @(negedge clk);
        v = fill(16'd22, 16'd23);
        @(negedge clk);
        vld2 = 1'b0;
        check("mid_pre_vld", vld_out2, 1);
        rst = 1'b1;
        #1;
        check("mid_vld_out", vld_out2, 0);
        check("mid_v_out",   el(v_out2, 0, 0), 0);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (vld_out2) stale++;
        end
        check("mid_stale", stale, 0);
        check("mid_rdy",   rdy_out2, 1);

`ifdef EXPMUL_UNDERFLOW_CNT_EN
        b = 16'h1000; a = {16'h1000, 16'h0000}; v = fill(16'd7, 16'd5);
        stream2(1);
        check("uf_one", ucnt2, 16);
        stream2(4094);
        check("uf_4095", ucnt2, 16'hFFF0);
        stream2(1);
        check("uf_sat", ucnt2, 16'hFFFF);
        stream2(1);
        check("uf_hold", ucnt2, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/expmul_array.md
Name: expmul_array

Overview:
- N-channel, parametrised-latency successor to the two-lane expmul pair.
- Each beat computes out[c][e] = 2^-(b - a[c]) * v[c][e] for every channel c and element e. One shared reference exponent b (running max m) is applied against a per-channel exponent a[c].
- All channels sit in a single joined pipeline under one valid/ready handshake, so lanes can never desynchronise.
- Sits between the score/max unit and the output accumulator in the attention datapath. Scores arrive pre-scaled by log2(e), hence base 2.

Parameters:
- NUM_CH, 2, number of channels (rescale lanes) per beat.
- VEC_LEN, 16, elements per channel vector.
- ELEM_W, 16, signed element width (two's complement).
- DIFF_W, 16, width of the a/b exponent operands (signed fixed point).
- FRAC_W, 8, fractional bits of a/b.
- STAGES, 2, pipeline depth; legal values 1..3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- vld_in  in  1  upstream beat valid.
- rdy_out  out  1  block can accept a beat.
- vld_out  out  1  output beat valid.
- rdy_in  in  1  downstream ready.
- b_in  in  DIFF_W  shared reference exponent (max).
- a_in  in  NUM_CH*DIFF_W  per-channel exponents; channel c occupies bits [c*DIFF_W +: DIFF_W].
- v_in  in  NUM_CH*VEC_LEN*ELEM_W  input vectors; channel-major, element-minor packing.
- v_out  out  NUM_CH*VEC_LEN*ELEM_W  scaled vectors; same packing as v_in.

Behaviour:
- Reset: asynchronous; all stage valid bits clear to 0 immediately. vld_out=0 and v_out=0 while rst is high. rdy_out=1 one cycle after rst deasserts.
- Handshake: a beat is accepted when vld_in && rdy_out. A beat is delivered when vld_out && rdy_in.
- Per-stage ready: ready[i] = !valid[i] || ready[i+1], with ready[STAGES] = rdy_in. rdy_out = ready[0].
  - Bubbles collapse; the pipeline holds up to STAGES beats.
  - rdy_out is combinational from rdy_in through the stage valids.
- Stall: a stage whose valid=1 while ready[i+1]=0 holds its data unchanged. Data changes only on a stage load.
- Latency: exactly STAGES cycles from acceptance to vld_out when not stalled. Throughput is 1 beat/cycle.
- Arithmetic, per channel c:
  - d = b_in - a_in[c], computed at DIFF_W+1 bits.
  - If d < 0 (a > b), clamp d to 0, giving out = v.
  - k = d >> FRAC_W (integer part); f = d[FRAC_W-1:0].
  - Per element: p = (v * f) >>> (FRAC_W+1), a signed floor shift, with the product computed at ELEM_W+FRAC_W+1 bits. This approximates 2^-f as 1 - f/2.
  - t = v - p. This fits in ELEM_W because |p| < |v|/2.
  - out = t >>> k (arithmetic). If k >= ELEM_W, out = 0, including for negative v.
- Stage mapping:
  - STAGES=1: everything in one registered stage.
  - STAGES=2: S1 registers {k, f, v}; S2 computes p, t and the shift.
  - STAGES=3: S1 registers {k, f, v}; S2 registers t; S3 shifts.
- Simultaneous accept and deliver with a full pipeline: allowed; occupancy is unchanged.
- rst asserted mid-stream: in-flight beats are discarded; nothing is emitted after release until new input arrives.
- vld_in dropping without acceptance is permitted; no beat is recorded.

Optional Feature:
- Macro: EXPMUL_UNDERFLOW_CNT_EN.
- Enabled:
  - Adds output port uflow_cnt [15:0].
  - Counts elements whose output was forced to 0 by the k >= ELEM_W rule, or whose nonzero v shifted to exactly 0.
  - Counted only on delivered beats (vld_out && rdy_in).
  - Saturates at 16'hFFFF; clears on rst.
- Disabled: the port and all counter logic are absent.

Test Plan:
- ELEM_W=16, FRAC_W=8, STAGES=2: v=1024, a=b=0x0300 -> out=1024 after exactly 2 cycles with rdy_in=1.
- Exponent cases, all with v=1024:
  - d=0x0100 -> 512.
  - d=0x0080 -> 768 (p=131072>>>9=256).
  - d=0x1000 (k=16) -> 0.
  - a>b (d=-0x0100) -> 1024.
- Negative input: v=-1024, d=0x0100 -> -512. v=-3, d=0x0100 -> -2 (floor shift).
- Backpressure, STAGES=3: rdy_in=0, vld_in=1 with beats 1..4 -> 3 accepted and rdy_out=0 on the 4th. Then rdy_in=1 -> beats delivered in order 1,2,3,4 with no loss or duplication; vld_out stays 1 until drained.
- Reset mid-stream: 2 beats in flight, assert rst for 1 cycle -> vld_out=0 at once, no stale beat after release, rdy_out=1.
- EXPMUL_UNDERFLOW_CNT_EN, NUM_CH=2, VEC_LEN=16: one beat with ch0 k=16 and ch1 d=0 -> uflow_cnt=16. After 4096 such beats -> uflow_cnt=16'hFFFF (saturated).
